// File: rtl/wb_regfile_stage_if.sv
// MEM/WB -> write-back stage bundle: MEM/WB register outputs, ID/debug read ports and status.
// The master side is the pipeline/debugger; the slave side is the write-back stage.
interface wb_regfile_stage_if #(
    parameter int unsigned INST_SZ = 32,
    parameter int unsigned CNT_SZ  = 32
);
    logic               i_enable;
    logic               i_halt;
    logic               i_reg_write;
    logic               i_mem_to_reg;
    logic               i_bds_sel;
    logic [INST_SZ-1:0] i_read_data;
    logic [INST_SZ-1:0] i_alu_result;
    logic [4:0]         i_write_register;
    logic [INST_SZ-1:0] i_bds;
    logic [4:0]         i_rs_addr;
    logic [4:0]         i_rt_addr;
    logic [4:0]         i_dbg_addr;
    logic               i_resume;

    logic [INST_SZ-1:0] o_rs_data;
    logic [INST_SZ-1:0] o_rt_data;
    logic [INST_SZ-1:0] o_dbg_data;
    logic [INST_SZ-1:0] o_wb_data;
    logic               o_halted;
    logic [CNT_SZ-1:0]  o_retired;

    modport master (
        output i_enable, i_halt, i_reg_write, i_mem_to_reg, i_bds_sel,
        output i_read_data, i_alu_result, i_write_register, i_bds,
        output i_rs_addr, i_rt_addr, i_dbg_addr, i_resume,
        input  o_rs_data, o_rt_data, o_dbg_data, o_wb_data, o_halted, o_retired
    );

    modport slave (
        input  i_enable, i_halt, i_reg_write, i_mem_to_reg, i_bds_sel,
        input  i_read_data, i_alu_result, i_write_register, i_bds,
        input  i_rs_addr, i_rt_addr, i_dbg_addr, i_resume,
        output o_rs_data, o_rt_data, o_dbg_data, o_wb_data, o_halted, o_retired
    );
endinterface

// File: rtl/wb_regfile_stage.sv
// Write-back stage: selects write-back data, commits it to the GPR file, serves two bypassed
// ID read ports plus a debug port, and tracks halt state and retired instructions.
module wb_regfile_stage #(
    parameter int unsigned INST_SZ = 32,
    parameter int unsigned NREG    = 32,
    parameter int unsigned CNT_SZ  = 32
) (
    input logic                i_clk,
    input logic                i_reset,
    wb_regfile_stage_if.slave  wb
);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e             state_q;
    state_e             state_d;
    logic               run;
    logic               retire;
    logic               wr_en;
    logic [INST_SZ-1:0] wb_data;
    logic [CNT_SZ-1:0]  retired_q;
    logic [INST_SZ-1:0] gpr_q [NREG];

    // Link address beats load data, which beats the ALU result.
    always_comb begin
        wb_data = wb.i_alu_result;
        if (wb.i_bds_sel) begin
            wb_data = wb.i_bds;
        end else if (wb.i_mem_to_reg) begin
            wb_data = wb.i_read_data;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; in RUN a halt takes priority over a simultaneous resume
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (wb.i_enable && wb.i_halt) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                if (wb.i_resume) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // FSM outputs and commit qualifiers
    always_comb begin
        run    = (state_q == StRun);
        retire = wb.i_enable && !wb.i_halt && run;
        wr_en  = retire && wb.i_reg_write && (wb.i_write_register != 5'd0);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                gpr_q[i] <= '0;
            end
        end else if (wr_en) begin
            gpr_q[wb.i_write_register] <= wb_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + CNT_SZ'(1);
        end
    end

    // Write-first bypass on the ID ports; debug sees only committed state.
    always_comb begin
        wb.o_rs_data  = '0;
        wb.o_rt_data  = '0;
        wb.o_dbg_data = '0;
        if (wb.i_rs_addr != 5'd0) begin
            wb.o_rs_data = (wr_en && wb.i_rs_addr == wb.i_write_register) ? wb_data
                                                                          : gpr_q[wb.i_rs_addr];
        end
        if (wb.i_rt_addr != 5'd0) begin
            wb.o_rt_data = (wr_en && wb.i_rt_addr == wb.i_write_register) ? wb_data
                                                                          : gpr_q[wb.i_rt_addr];
        end
        if (wb.i_dbg_addr != 5'd0) begin
            wb.o_dbg_data = gpr_q[wb.i_dbg_addr];
        end
    end

    assign wb.o_wb_data = wb_data;
    assign wb.o_halted  = (state_q == StHalted);
    assign wb.o_retired = retired_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed bench for wb_regfile_stage; small 4-bit counter so the wrap is reachable quickly.
module tb_wb_regfile_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    wb_regfile_stage_if #(.INST_SZ(32), .CNT_SZ(4)) bus ();

    wb_regfile_stage #(
        .INST_SZ (32),
        .NREG    (32),
        .CNT_SZ  (4)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .wb      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle 2 time units past it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_wb(input logic en, input logic rw, input logic m2r, input logic bsel,
                          input logic [4:0] dst, input logic [31:0] alu,
                          input logic [31:0] rd, input logic [31:0] bds);
        bus.i_enable         = en;
        bus.i_reg_write      = rw;
        bus.i_mem_to_reg     = m2r;
        bus.i_bds_sel        = bsel;
        bus.i_write_register = dst;
        bus.i_alu_result     = alu;
        bus.i_read_data      = rd;
        bus.i_bds            = bds;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.i_halt    = 1'b0;
        bus.i_resume  = 1'b0;
        bus.i_rs_addr = 5'd5;
        bus.i_rt_addr = 5'd31;
        bus.i_dbg_addr = 5'd7;
        set_wb(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);

        // Reset state
        #3;
        check_eq("rst_rs", bus.o_rs_data, 32'h0);
        check_eq("rst_rt", bus.o_rt_data, 32'h0);
        check_eq("rst_dbg", bus.o_dbg_data, 32'h0);
        check_eq("rst_halted", {31'b0, bus.o_halted}, 32'h0);
        check_eq("rst_retired", {28'b0, bus.o_retired}, 32'h0);
        #4;
        rst_n = 1'b1;
        tick();

        // Write-back select priority
        bus.i_dbg_addr = 5'd5;
        set_wb(1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 32'h11, 32'h22, 32'h33);
        check_eq("sel_bds_wb", bus.o_wb_data, 32'h33);
        tick();
        check_eq("sel_bds_gpr", bus.o_dbg_data, 32'h33);
        check_eq("sel_bds_ret", {28'b0, bus.o_retired}, 32'h1);
        set_wb(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 32'h11, 32'h22, 32'h33);
        check_eq("sel_mem_wb", bus.o_wb_data, 32'h22);
        tick();
        check_eq("sel_mem_gpr", bus.o_dbg_data, 32'h22);
        check_eq("sel_mem_ret", {28'b0, bus.o_retired}, 32'h2);
        set_wb(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h11, 32'h22, 32'h33);
        check_eq("sel_alu_wb", bus.o_wb_data, 32'h11);
        tick();
        check_eq("sel_alu_gpr", bus.o_dbg_data, 32'h11);
        check_eq("sel_alu_ret", {28'b0, bus.o_retired}, 32'h3);

        // Bypass and GPR0
        bus.i_rs_addr  = 5'd7;
        bus.i_rt_addr  = 5'd5;
        bus.i_dbg_addr = 5'd7;
        set_wb(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'hDEADBEEF, 32'h0, 32'h0);
        check_eq("byp_rs", bus.o_rs_data, 32'hDEADBEEF);
        check_eq("byp_dbg_old", bus.o_dbg_data, 32'h0);
        check_eq("byp_rt_other", bus.o_rt_data, 32'h11);
        tick();
        check_eq("byp_dbg_new", bus.o_dbg_data, 32'hDEADBEEF);
        bus.i_rs_addr  = 5'd0;
        bus.i_rt_addr  = 5'd0;
        bus.i_dbg_addr = 5'd0;
        set_wb(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h55, 32'h0, 32'h0);
        check_eq("zero_rs_byp", bus.o_rs_data, 32'h0);
        tick();
        check_eq("zero_rs", bus.o_rs_data, 32'h0);
        check_eq("zero_rt", bus.o_rt_data, 32'h0);
        check_eq("zero_dbg", bus.o_dbg_data, 32'h0);
        check_eq("zero_ret", {28'b0, bus.o_retired}, 32'h5);

        // Halt: halting instruction neither writes nor counts
        bus.i_rs_addr  = 5'd3;
        bus.i_dbg_addr = 5'd3;
        bus.i_halt     = 1'b1;
        set_wb(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h77, 32'h0, 32'h0);
        check_eq("halt_no_byp", bus.o_rs_data, 32'h0);
        tick();
        check_eq("halt_flag", {31'b0, bus.o_halted}, 32'h1);
        check_eq("halt_gpr", bus.o_dbg_data, 32'h0);
        check_eq("halt_ret", {28'b0, bus.o_retired}, 32'h5);
        bus.i_halt = 1'b0;
        set_wb(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h88, 32'h0, 32'h0);
        check_eq("halted_no_byp", bus.o_rs_data, 32'h0);
        tick();
        tick();
        check_eq("halted_gpr", bus.o_dbg_data, 32'h0);
        check_eq("halted_ret", {28'b0, bus.o_retired}, 32'h5);
        check_eq("halted_stay", {31'b0, bus.o_halted}, 32'h1);
        bus.i_resume = 1'b1;
        set_wb(1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h88, 32'h0, 32'h0);
        tick();
        bus.i_resume = 1'b0;
        check_eq("resume_flag", {31'b0, bus.o_halted}, 32'h0);
        check_eq("resume_gpr", bus.o_dbg_data, 32'h0);
        set_wb(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h88, 32'h0, 32'h0);
        tick();
        check_eq("resume_write", bus.o_dbg_data, 32'h88);
        check_eq("resume_ret", {28'b0, bus.o_retired}, 32'h6);
        // Halt and resume together in RUN: halt wins
        bus.i_halt   = 1'b1;
        bus.i_resume = 1'b1;
        set_wb(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        check_eq("halt_wins", {31'b0, bus.o_halted}, 32'h1);
        bus.i_halt = 1'b0;
        set_wb(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        bus.i_resume = 1'b0;
        check_eq("halt_wins_exit", {31'b0, bus.o_halted}, 32'h0);
        check_eq("halt_wins_ret", {28'b0, bus.o_retired}, 32'h6);

        // Stall: no writes, count frozen
        bus.i_rs_addr  = 5'd9;
        bus.i_dbg_addr = 5'd9;
        set_wb(1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 32'h99, 32'h0, 32'h0);
        check_eq("stall_no_byp", bus.o_rs_data, 32'h0);
        for (int i = 0; i < 10; i++) tick();
        check_eq("stall_gpr", bus.o_dbg_data, 32'h0);
        check_eq("stall_ret", {28'b0, bus.o_retired}, 32'h6);

        // Wrap: ten bubbles reach 16 retirements since reset
        set_wb(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h99, 32'h0, 32'h0);
        for (int i = 0; i < 9; i++) tick();
        check_eq("wrap_pre", {28'b0, bus.o_retired}, 32'hF);
        check_eq("bubble_gpr", bus.o_dbg_data, 32'h0);
        tick();
        check_eq("wrap_zero", {28'b0, bus.o_retired}, 32'h0);

        // Async reset between edges
        bus.i_dbg_addr = 5'd10;
        set_wb(1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 32'hA5A5A5A5, 32'h0, 32'h0);
        tick();
        check_eq("pre_rst_gpr", bus.o_dbg_data, 32'hA5A5A5A5);
        check_eq("pre_rst_ret", {28'b0, bus.o_retired}, 32'h1);
        set_wb(1'b1, 1'b1, 1'b0, 1'b0, 5'd11, 32'h1234, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        check_eq("arst_gpr", bus.o_dbg_data, 32'h0);
        check_eq("arst_ret", {28'b0, bus.o_retired}, 32'h0);
        bus.i_dbg_addr = 5'd3;
        #1;
        check_eq("arst_gpr3", bus.o_dbg_data, 32'h0);
        tick();
        bus.i_dbg_addr = 5'd11;
        #1;
        check_eq("arst_edge_nowrite", bus.o_dbg_data, 32'h0);
        rst_n = 1'b1;
        set_wb(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        check_eq("post_rst_ret", {28'b0, bus.o_retired}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
